// File: rtl/adder_pkg.sv
// Shared definitions for the byte-serial adder datapath.
package adder_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } bsa_state_t;

endpackage

// File: rtl/rca8.sv
// 8-bit ripple-carry adder slice used one byte at a time by the serial adder.
module rca8
    import adder_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
    assign sum  = full[BYTE_W-1:0];
    assign cout = full[BYTE_W];

endmodule

// File: rtl/byte_serial_adder.sv
// Multi-byte adder: one RCA8 pass per cycle, LSB first, with carry held in a register
// between bytes and valid/ready handshakes on both sides.
module byte_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a_in,
    input  logic [BYTE_W*NBYTES-1:0] b_in,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum_out,
    output logic                     cout_out,
    output logic                     ovf_out
);

    localparam int unsigned W  = BYTE_W * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    bsa_state_t    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [BYTE_W-1:0] rca_a;
    logic [BYTE_W-1:0] rca_b;
    logic [BYTE_W-1:0] rca_sum;
    logic              rca_cout;

    assign rca_a = a_q[idx_q*BYTE_W +: BYTE_W];
    assign rca_b = b_q[idx_q*BYTE_W +: BYTE_W];

    rca8 u_rca8 (
        .a    (rca_a),
        .b    (rca_b),
        .cin  (carry_q),
        .sum  (rca_sum),
        .cout (rca_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = cin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                sum_d[idx_q*BYTE_W +: BYTE_W] = rca_sum;
                carry_d = rca_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                    cout_d  = rca_cout;
                    // Top byte of the sum is only now known, so take its MSB from the adder.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (rca_sum[BYTE_W-1] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum_out   = sum_q;
    assign cout_out  = cout_q;
    assign ovf_out   = ovf_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Scoreboard bench for byte_serial_adder: a 4-byte and a 1-byte instance share clock and reset.
module tb_byte_serial_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, ovf4;
    logic [31:0] a4, b4, sum4;

    logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, ovf1;
    logic [7:0]  a1, b1, sum1;

    exp_t q4[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    byte_serial_adder #(.NBYTES(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a_in      (a4),
        .b_in      (b4),
        .cin       (cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum_out   (sum4),
        .cout_out  (cout4),
        .ovf_out   (ovf4)
    );

    byte_serial_adder #(.NBYTES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a_in      (a1),
        .b_in      (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum_out   (sum1),
        .cout_out  (cout1),
        .ovf_out   (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitors: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                chk("dut4 unexpected result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("dut4 sum", sum4, e.sum);
                chk("dut4 cout", {31'd0, cout4}, {31'd0, e.cout});
                chk("dut4 ovf", {31'd0, ovf4}, {31'd0, e.ovf});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1 sum", {24'd0, sum1}, e.sum);
                chk("dut1 cout", {31'd0, cout1}, {31'd0, e.cout});
                chk("dut1 ovf", {31'd0, ovf1}, {31'd0, e.ovf});
            end
        end
    end

    // Issue one operation on the 4-byte DUT and check out_valid rises NBYTES edges later.
    task automatic send4(input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic [31:0] es, input logic ec, input logic eo);
        int n;
        n = 0;
        while (!in_ready4 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("dut4 in_ready wait", {31'd0, in_ready4}, 32'd1);
        q4.push_back('{sum: es, cout: ec, ovf: eo});
        in_valid4 = 1'b1; a4 = a; b4 = b; cin4 = c;
        @(posedge clk); #1;
        in_valid4 = 1'b0; a4 = $urandom; b4 = $urandom; cin4 = 1'b1;
        n = 0;
        while (!out_valid4 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("dut4 latency", n, 32'd4);
    endtask

    task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] es, input logic ec, input logic eo);
        int n;
        n = 0;
        while (!in_ready1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("dut1 in_ready wait", {31'd0, in_ready1}, 32'd1);
        q1.push_back('{sum: {24'd0, es}, cout: ec, ovf: eo});
        in_valid1 = 1'b1; a1 = a; b1 = b; cin1 = c;
        @(posedge clk); #1;
        in_valid1 = 1'b0; a1 = 8'hA5; b1 = 8'h5A;
        n = 0;
        while (!out_valid1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("dut1 latency", n, 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("reset in_ready4", {31'd0, in_ready4}, 32'd1);
        chk("reset out_valid4", {31'd0, out_valid4}, 32'd0);
        chk("reset sum4", sum4, 32'd0);
        chk("reset cout4/ovf4", {30'd0, cout4, ovf4}, 32'd0);
        chk("reset in_ready1", {31'd0, in_ready1}, 32'd1);
        chk("reset out_valid1", {31'd0, out_valid1}, 32'd0);

        send4(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        send4(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        send4(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send4(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

        // Backpressure: result must hold and new operands must be ignored.
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        send4(32'h0001_0001, 32'h0000_FFFF, 1'b0, 32'h0002_0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid4 = 1'b1; a4 = $urandom; b4 = $urandom;
            @(posedge clk); #1;
            chk("bp out_valid", {31'd0, out_valid4}, 32'd1);
            chk("bp in_ready", {31'd0, in_ready4}, 32'd0);
            chk("bp sum stable", sum4, 32'h0002_0000);
        end
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        chk("bp release in_ready", {31'd0, in_ready4}, 32'd1);
        chk("bp release out_valid", {31'd0, out_valid4}, 32'd0);
        chk("bp release sum held", sum4, 32'h0002_0000);
        chk("bp queue drained", q4.size(), 32'd0);

        // Reset after two bytes have been processed; no result may appear.
        in_valid4 = 1'b1; a4 = 32'hDEAD_BEEF; b4 = 32'h0123_4567; cin4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort out_valid", {31'd0, out_valid4}, 32'd0);
        chk("abort sum", sum4, 32'd0);
        chk("abort in_ready", {31'd0, in_ready4}, 32'd1);
        chk("abort cout", {31'd0, cout4}, 32'd0);
        send4(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        // Single-byte instance.
        send1(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        send1(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        send1(8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);

        n = 0;
        while ((q4.size() != 0 || q1.size() != 0) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("final queue4 empty", q4.size(), 32'd0);
        chk("final queue1 empty", q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
